// File: rtl/ym_wr_queue.sv
// ym_wr_queue
// Host-write queue between an asynchronous YM2151-style CPU bus and one or
// more jt51 cores. The bus write strobe is synchronised into ymclk. Each
// completed bus write is buffered in a DEPTH-entry FIFO. Writes are then
// replayed to the selected core(s) as one-cycle synchronous writes. Replays
// are spaced by a per-type busy gap: GAP after a data write, ADDR_GAP after
// an address write.
//
// Ports
//   ymclk, rst_n        core clock, asynchronous active-low reset
//   bus_cs_n[NCS]       asynchronous chip selects (several low = broadcast)
//   bus_wr_n, bus_a0    asynchronous write strobe and address/data select
//   bus_din[DW]         asynchronous write data
//   flush               synchronous FIFO clear, also aborts pacing
//   clr_ovf             clears the sticky overflow flag
//   core_wr_n           one-cycle active-low write to the cores
//   core_sel[NCS]       core select, non-zero only while core_wr_n=0
//   core_a0, core_dout  replayed a0/data, held after the pulse
//   fifo_level          occupancy, $clog2(DEPTH)+1 bits
//   fifo_full           level==DEPTH
//   overflow            sticky: a bus write was dropped
//   busy                FIFO non-empty or replay FSM not idle
module ym_wr_queue #(
  parameter int DW       = 8,
  parameter int DEPTH    = 16,
  parameter int NCS      = 1,
  parameter int GAP      = 64,
  parameter int ADDR_GAP = 2
) (
  input  logic                   ymclk,
  input  logic                   rst_n,
  input  logic [NCS-1:0]         bus_cs_n,
  input  logic                   bus_wr_n,
  input  logic                   bus_a0,
  input  logic [DW-1:0]          bus_din,
  input  logic                   flush,
  input  logic                   clr_ovf,
  output logic                   core_wr_n,
  output logic [NCS-1:0]         core_sel,
  output logic                   core_a0,
  output logic [DW-1:0]          core_dout,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic                   busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int EW   = NCS + 1 + DW;
  localparam int MAXG = (GAP > ADDR_GAP) ? GAP : ADDR_GAP;
  localparam int CW   = $clog2(MAXG);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_t;

  // ---- bus synchronisers and capture ----
  logic           strobe_n;
  logic           s1, s2, s3;
  logic [DW-1:0]  din_s1, din_s2, cap_din;
  logic           a0_s1, a0_s2, cap_a0;
  logic [NCS-1:0] sel_s1, sel_s2, cap_sel;
  logic           push;

  assign strobe_n = bus_wr_n | (&bus_cs_n);

  // Reset to 1 so that leaving reset never looks like a strobe rising edge.
  always_ff @(posedge ymclk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= strobe_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // The capture register tracks the bus while the strobe is low. It freezes
  // once the synchronised strobe rises, so the push sees the final values.
  always_ff @(posedge ymclk) begin
    din_s1 <= bus_din;
    din_s2 <= din_s1;
    a0_s1  <= bus_a0;
    a0_s2  <= a0_s1;
    sel_s1 <= ~bus_cs_n;
    sel_s2 <= sel_s1;
    if (!s2) begin
      cap_din <= din_s2;
      cap_a0  <= a0_s2;
      cap_sel <= sel_s2;
    end
  end

  assign push = s2 & ~s3;

  // ---- FIFO ----
  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [EW-1:0]  head;
  logic [NCS-1:0] head_sel;
  logic           head_a0;
  logic [DW-1:0]  head_dout;
  logic           empty, pop, wr_en, drop;
  logic [LW-1:0]  level_nxt;

  assign head      = mem[rd_ptr];
  assign head_sel  = head[EW-1 -: NCS];
  assign head_a0   = head[DW];
  assign head_dout = head[DW-1:0];
  assign empty     = (fifo_level == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign wr_en = push & ~flush & (~fifo_full | pop);
  assign drop  = push & ~flush & fifo_full & ~pop;

  always_comb begin
    level_nxt = fifo_level;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   level_nxt = fifo_level + LW'(1);
        2'b01:   level_nxt = fifo_level - LW'(1);
        default: level_nxt = fifo_level;
      endcase
    end
  end

  always_ff @(posedge ymclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {cap_sel, cap_a0, cap_din};
    end
  end

  // ---- replay FSM ----
  state_t        state, state_nxt;
  logic [CW-1:0] gap_cnt, gap_ld;

  always_ff @(posedge ymclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (!empty) state_nxt = ST_ISSUE;
        ST_ISSUE: state_nxt = ST_WAIT;
        ST_WAIT:  if (gap_cnt == '0) state_nxt = empty ? ST_IDLE : ST_ISSUE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // The pulse, the pop and the counter load share the edge that enters ISSUE.
  // ISSUE then lasts exactly one cycle, and the two-cycle minimum gap is
  // covered by ISSUE plus the final WAIT cycle, hence the -2.
  always_comb begin
    pop    = 1'b0;
    gap_ld = '0;
    if (state_nxt == ST_ISSUE) begin
      pop    = 1'b1;
      gap_ld = head_a0 ? CW'(GAP - 2) : CW'(ADDR_GAP - 2);
    end
  end

  // ---- registered state and outputs ----
  always_ff @(posedge ymclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      gap_cnt    <= '0;
      core_wr_n  <= 1'b1;
      core_sel   <= '0;
      core_a0    <= 1'b0;
      core_dout  <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (pop)   rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_level <= level_nxt;
      fifo_full  <= (level_nxt == LW'(DEPTH));
      busy       <= (level_nxt != '0) || (state_nxt != ST_IDLE);

      // A drop takes priority, so a coincident clear cannot hide it.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (flush)                                  gap_cnt <= '0;
      else if (pop)                               gap_cnt <= gap_ld;
      else if (state == ST_WAIT && gap_cnt != '0) gap_cnt <= gap_cnt - CW'(1);

      core_wr_n <= ~pop;
      core_sel  <= pop ? head_sel : '0;
      if (pop) begin
        core_a0   <= head_a0;
        core_dout <= head_dout;
      end
    end
  end

endmodule

// File: tb/tb_ym_wr_queue.sv
// Testbench for ym_wr_queue.
// dut_a: default parameters (DEPTH=16, NCS=1, GAP=64, ADDR_GAP=2).
// dut_b: DEPTH=4, NCS=2, used for the table vectors and the overflow case.
module tb_ym_wr_queue;

  logic ymclk = 1'b0;
  logic rst_n;
  always #5 ymclk = ~ymclk;

  // dut_a signals
  logic       a_cs_n, a_wr_n, a_a0, a_flush, a_clr;
  logic [7:0] a_din;
  logic       a_core_wr_n, a_core_a0, a_fifo_full, a_overflow, a_busy;
  logic [0:0] a_core_sel;
  logic [7:0] a_core_dout;
  logic [4:0] a_fifo_level;

  // dut_b signals
  logic [1:0] b_cs_n;
  logic       b_wr_n, b_a0, b_flush, b_clr;
  logic [7:0] b_din;
  logic       b_core_wr_n, b_core_a0, b_fifo_full, b_overflow, b_busy;
  logic [1:0] b_core_sel;
  logic [7:0] b_core_dout;
  logic [2:0] b_fifo_level;

  ym_wr_queue dut_a (
    .ymclk(ymclk), .rst_n(rst_n), .bus_cs_n(a_cs_n), .bus_wr_n(a_wr_n),
    .bus_a0(a_a0), .bus_din(a_din), .flush(a_flush), .clr_ovf(a_clr),
    .core_wr_n(a_core_wr_n), .core_sel(a_core_sel), .core_a0(a_core_a0),
    .core_dout(a_core_dout), .fifo_level(a_fifo_level), .fifo_full(a_fifo_full),
    .overflow(a_overflow), .busy(a_busy)
  );

  ym_wr_queue #(.DW(8), .DEPTH(4), .NCS(2), .GAP(64), .ADDR_GAP(2)) dut_b (
    .ymclk(ymclk), .rst_n(rst_n), .bus_cs_n(b_cs_n), .bus_wr_n(b_wr_n),
    .bus_a0(b_a0), .bus_din(b_din), .flush(b_flush), .clr_ovf(b_clr),
    .core_wr_n(b_core_wr_n), .core_sel(b_core_sel), .core_a0(b_core_a0),
    .core_dout(b_core_dout), .fifo_level(b_fifo_level), .fifo_full(b_fifo_full),
    .overflow(b_overflow), .busy(b_busy)
  );

  typedef struct {
    longint     t;
    logic [1:0] sel;
    logic       a0;
    logic [7:0] d;
  } pulse_t;

  pulse_t qa[$];
  pulse_t qb[$];

  // Record every replay pulse, sampled on the falling edge.
  always @(negedge ymclk) begin
    if (a_core_wr_n === 1'b0) qa.push_back('{t: $time, sel: {1'b0, a_core_sel}, a0: a_core_a0, d: a_core_dout});
    if (b_core_wr_n === 1'b0) qb.push_back('{t: $time, sel: b_core_sel, a0: b_core_a0, d: b_core_dout});
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One bus write. ctl: 0 none, 1 clr_ovf, 2 flush, pulsed so that it is
  // sampled on the same edge as the resulting push.
  task automatic bus_wr(input bit to_b, input logic [1:0] cs, input logic a0,
                        input logic [7:0] d, input int ctl, output longint t_rise);
    @(negedge ymclk);
    if (to_b) begin b_cs_n = cs; b_a0 = a0; b_din = d; b_wr_n = 1'b0; end
    else      begin a_cs_n = cs[0]; a_a0 = a0; a_din = d; a_wr_n = 1'b0; end
    repeat (4) @(negedge ymclk);
    if (to_b) b_wr_n = 1'b1; else a_wr_n = 1'b1;
    t_rise = $time;
    @(negedge ymclk);
    if (to_b) b_cs_n = 2'b11; else a_cs_n = 1'b1;
    @(negedge ymclk);
    if (ctl == 1) begin if (to_b) b_clr = 1'b1; else a_clr = 1'b1; end
    if (ctl == 2) begin if (to_b) b_flush = 1'b1; else a_flush = 1'b1; end
    @(negedge ymclk);
    a_clr = 1'b0; b_clr = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
  endtask

  task automatic wait_pulses(input bit to_b, input int n, input int budget);
    int k = 0;
    while (((to_b ? qb.size() : qa.size()) < n) && k < budget) begin
      @(negedge ymclk);
      k++;
    end
    chk("pulse_wait", 64'(to_b ? qb.size() : qa.size()), 64'(n));
  endtask

  task automatic wait_idle(input bit to_b, input int budget, output longint t_idle);
    int k = 0;
    while ((to_b ? b_busy : a_busy) && k < budget) begin
      @(negedge ymclk);
      k++;
    end
    t_idle = $time;
    chk("idle_wait", 64'(to_b ? b_busy : a_busy), 64'(0));
  endtask

  typedef struct {
    logic [1:0] cs_n;
    logic       a0;
    logic [7:0] din;
    logic [1:0] exp_sel;
    logic       exp_a0;
    logic [7:0] exp_dout;
    int         exp_gap;
  } vec_t;

  vec_t       vec [5];
  logic [7:0] ovd [7];

  initial begin
    longint tr, ti;

    vec[0] = '{2'b10, 1'b0, 8'h28, 2'b01, 1'b0, 8'h28, 2};
    vec[1] = '{2'b01, 1'b1, 8'hC7, 2'b10, 1'b1, 8'hC7, 64};
    vec[2] = '{2'b00, 1'b1, 8'h55, 2'b11, 1'b1, 8'h55, 64};
    vec[3] = '{2'b00, 1'b0, 8'hA3, 2'b11, 1'b0, 8'hA3, 2};
    vec[4] = '{2'b10, 1'b1, 8'h00, 2'b01, 1'b1, 8'h00, 64};
    ovd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

    a_cs_n = 1'b1; a_wr_n = 1'b1; a_a0 = 1'b0; a_din = 8'h00; a_flush = 1'b0; a_clr = 1'b0;
    b_cs_n = 2'b11; b_wr_n = 1'b1; b_a0 = 1'b0; b_din = 8'h00; b_flush = 1'b0; b_clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge ymclk);

    // Reset state
    chk("rst_wr_n",  64'(a_core_wr_n),  64'(1));
    chk("rst_sel",   64'(a_core_sel),   64'(0));
    chk("rst_a0",    64'(a_core_a0),    64'(0));
    chk("rst_dout",  64'(a_core_dout),  64'(0));
    chk("rst_level", 64'(a_fifo_level), 64'(0));
    chk("rst_full",  64'(a_fifo_full),  64'(0));
    chk("rst_ovf",   64'(a_overflow),   64'(0));
    chk("rst_busy",  64'(a_busy),       64'(0));
    chk("rst_b_wr_n", 64'(b_core_wr_n), 64'(1));
    chk("rst_b_busy", 64'(b_busy),      64'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge ymclk);
    chk("rel_no_push", 64'(a_fifo_level), 64'(0));

    // Single address write 0x28 on dut_a
    qa.delete();
    bus_wr(1'b0, 2'b00, 1'b0, 8'h28, 0, tr);
    chk("single_level", 64'(a_fifo_level), 64'(1));
    chk("single_busy",  64'(a_busy),       64'(1));
    wait_pulses(1'b0, 1, 20);
    wait_idle(1'b0, 100, ti);
    chk("single_count", 64'(qa.size()), 64'(1));
    if (qa.size() > 0) begin
      chk("single_lat",  64'(qa[0].t - tr), 64'(40));
      chk("single_sel",  64'(qa[0].sel),    64'(1));
      chk("single_a0",   64'(qa[0].a0),     64'(0));
      chk("single_dout", 64'(qa[0].d),      64'(8'h28));
      chk("single_gap",  64'(ti - qa[0].t), 64'(20));
    end
    chk("single_sel_idle", 64'(a_core_sel),  64'(0));
    chk("single_hold",     64'(a_core_dout), 64'(8'h28));

    // Table vectors on dut_b (includes a broadcast)
    for (int i = 0; i < 5; i++) begin
      qb.delete();
      bus_wr(1'b1, vec[i].cs_n, vec[i].a0, vec[i].din, 0, tr);
      wait_pulses(1'b1, 1, 20);
      wait_idle(1'b1, 200, ti);
      chk($sformatf("vec%0d_count", i), 64'(qb.size()), 64'(1));
      if (qb.size() > 0) begin
        chk($sformatf("vec%0d_lat", i),  64'(qb[0].t - tr), 64'(40));
        chk($sformatf("vec%0d_sel", i),  64'(qb[0].sel),    64'(vec[i].exp_sel));
        chk($sformatf("vec%0d_a0", i),   64'(qb[0].a0),     64'(vec[i].exp_a0));
        chk($sformatf("vec%0d_dout", i), 64'(qb[0].d),      64'(vec[i].exp_dout));
        chk($sformatf("vec%0d_gap", i),  64'(ti - qb[0].t), 64'(vec[i].exp_gap * 10));
      end
      chk($sformatf("vec%0d_sel_idle", i), 64'(b_core_sel),  64'(0));
      chk($sformatf("vec%0d_hold", i),     64'(b_core_dout), 64'(vec[i].exp_dout));
    end

    // Burst: a data write holds the FSM, then 4 addr/data pairs queue behind it
    qa.delete();
    bus_wr(1'b0, 2'b00, 1'b1, 8'h00, 0, tr);
    for (int k = 0; k < 4; k++) begin
      bus_wr(1'b0, 2'b00, 1'b0, 8'h20, 0, tr);
      bus_wr(1'b0, 2'b00, 1'b1, 8'hC7, 0, tr);
    end
    wait_pulses(1'b0, 9, 700);
    wait_idle(1'b0, 200, ti);
    chk("burst_count", 64'(qa.size()), 64'(9));
    chk("burst_ovf",   64'(a_overflow), 64'(0));
    if (qa.size() == 9) begin
      for (int k = 1; k < 9; k++) begin
        chk($sformatf("burst%0d_a0", k),   64'(qa[k].a0), 64'((k % 2 == 1) ? 0 : 1));
        chk($sformatf("burst%0d_dout", k), 64'(qa[k].d),  64'((k % 2 == 1) ? 8'h20 : 8'hC7));
        chk($sformatf("burst%0d_space", k), 64'(qa[k].t - qa[k-1].t),
            64'(((k - 1) % 2 == 1) ? 20 : 640));
      end
    end

    // Overflow on dut_b (DEPTH=4): 1 popped + 4 queued, 6th dropped
    qb.delete();
    for (int k = 0; k < 6; k++) bus_wr(1'b1, 2'b10, 1'b1, ovd[k], 0, tr);
    chk("ovf_set",   64'(b_overflow),   64'(1));
    chk("ovf_level", 64'(b_fifo_level), 64'(4));
    chk("ovf_full",  64'(b_fifo_full),  64'(1));
    bus_wr(1'b1, 2'b10, 1'b1, ovd[6], 1, tr);
    chk("ovf_clr_vs_drop", 64'(b_overflow), 64'(1));
    @(negedge ymclk); b_clr = 1'b1;
    @(negedge ymclk); b_clr = 1'b0;
    chk("ovf_cleared",     64'(b_overflow),   64'(0));
    chk("ovf_level_after", 64'(b_fifo_level), 64'(4));
    wait_pulses(1'b1, 5, 400);
    wait_idle(1'b1, 200, ti);
    chk("ovf_count", 64'(qb.size()), 64'(5));
    if (qb.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("ovf%0d_dout", k), 64'(qb[k].d), 64'(ovd[k]));
        if (k > 0) chk($sformatf("ovf%0d_space", k), 64'(qb[k].t - qb[k-1].t), 64'(640));
      end
    end

    // Flush with 3 entries queued, coincident with a push
    qa.delete();
    bus_wr(1'b0, 2'b00, 1'b1, 8'h31, 0, tr);
    bus_wr(1'b0, 2'b00, 1'b0, 8'h32, 0, tr);
    bus_wr(1'b0, 2'b00, 1'b1, 8'h33, 0, tr);
    bus_wr(1'b0, 2'b00, 1'b0, 8'h34, 0, tr);
    chk("flush_pre_level", 64'(a_fifo_level), 64'(3));
    bus_wr(1'b0, 2'b00, 1'b1, 8'h35, 2, tr);
    chk("flush_level", 64'(a_fifo_level), 64'(0));
    chk("flush_busy",  64'(a_busy),       64'(0));
    chk("flush_ovf",   64'(a_overflow),   64'(0));
    repeat (150) @(negedge ymclk);
    chk("flush_no_pulses", 64'(qa.size()), 64'(1));

    // Reset in WAIT with entries queued
    qa.delete();
    bus_wr(1'b0, 2'b00, 1'b1, 8'h9A, 0, tr);
    bus_wr(1'b0, 2'b00, 1'b0, 8'h01, 0, tr);
    bus_wr(1'b0, 2'b00, 1'b1, 8'h02, 0, tr);
    chk("rstw_pre_level", 64'(a_fifo_level), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_wr_n",  64'(a_core_wr_n),  64'(1));
    chk("rstw_sel",   64'(a_core_sel),   64'(0));
    chk("rstw_a0",    64'(a_core_a0),    64'(0));
    chk("rstw_dout",  64'(a_core_dout),  64'(0));
    chk("rstw_level", 64'(a_fifo_level), 64'(0));
    chk("rstw_full",  64'(a_fifo_full),  64'(0));
    chk("rstw_busy",  64'(a_busy),       64'(0));
    repeat (3) @(negedge ymclk);
    rst_n = 1'b1;
    repeat (100) @(negedge ymclk);
    chk("rstw_no_more_pulses", 64'(qa.size()), 64'(1));
    chk("rstw_level_after",    64'(a_fifo_level), 64'(0));
    chk("rstw_busy_after",     64'(a_busy),       64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
